// File: rtl/cache_arbiter_if.sv
// Bundle of I-cache, D-cache and physical-memory signals seen by the cache arbiter.
// The slave modport is the arbiter's view; the master modport is the caches-plus-memory side.
interface cache_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic                  i_pmem_read;
    logic [ADDR_WIDTH-1:0] i_pmem_address;
    logic [LINE_WIDTH-1:0] i_pmem_rdata;
    logic                  i_pmem_resp;

    logic                  d_pmem_read;
    logic                  d_pmem_write;
    logic [ADDR_WIDTH-1:0] d_pmem_address;
    logic [LINE_WIDTH-1:0] d_pmem_wdata;
    logic [LINE_WIDTH-1:0] d_pmem_rdata;
    logic                  d_pmem_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  i_pmem_read, i_pmem_address,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  pmem_rdata, pmem_resp,
        output i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_pmem_read, i_pmem_address,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output pmem_rdata, pmem_resp,
        input  i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// Two-requester arbiter sharing one physical memory port between I-cache and D-cache; one idle bubble between grants.
// Simultaneous requests: D-cache wins, or alternate with last_grant when CACHE_ARB_ROUND_ROBIN_EN is defined.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic            clk,
    input  logic            rst,
    cache_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        s_idle,
        s_icache,
        s_dcache
    } state_e;

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  i_req, d_req, pick_d;
    logic [ADDR_WIDTH-1:0] addr_mux;
    logic [LINE_WIDTH-1:0] wdata_mux;

    assign i_req = bus.i_pmem_read;
    assign d_req = bus.d_pmem_read | bus.d_pmem_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    assign pick_d = (last_grant_q == 1'b0);
`else
    assign pick_d = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= s_idle;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        addr_mux       = '0;
        wdata_mux      = '0;
        bus.i_pmem_resp = 1'b0;
        bus.d_pmem_resp = 1'b0;

        case (state_q)
            s_idle: begin
                // memory responses arriving here belong to nobody and are dropped
                if (d_req && (!i_req || pick_d)) begin
                    state_d      = s_dcache;
                    last_grant_d = 1'b1;
                end else if (i_req) begin
                    state_d      = s_icache;
                    last_grant_d = 1'b0;
                end
            end
            s_icache: begin
                bus.pmem_read   = bus.i_pmem_read;
                addr_mux        = bus.i_pmem_address;
                bus.i_pmem_resp = bus.pmem_resp;
                if (bus.pmem_resp) begin
                    state_d = s_idle;
                end
            end
            s_dcache: begin
                bus.pmem_read   = bus.d_pmem_read;
                bus.pmem_write  = bus.d_pmem_write;
                addr_mux        = bus.d_pmem_address;
                wdata_mux       = bus.d_pmem_wdata;
                bus.d_pmem_resp = bus.pmem_resp;
                if (bus.pmem_resp) begin
                    state_d = s_idle;
                end
            end
            default: begin
                state_d = s_idle;
            end
        endcase
    end

    assign bus.pmem_address = addr_mux;
    assign bus.pmem_wdata   = wdata_mux;
    assign bus.i_pmem_rdata = bus.pmem_rdata;
    assign bus.d_pmem_rdata = bus.pmem_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed vector table, simultaneous-request grant order, random run vs. reference model.
module tb_cache_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();
    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        rst;
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [7:0]  wd;
        logic        resp;
        logic        er;
        logic        ew;
        logic [31:0] ea;
        logic [7:0]  ewd;
        logic        eir;
        logic        edr;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    function automatic vec_t mk(logic r, logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                                logic [7:0] wd, logic resp, logic er, logic ew, logic [31:0] ea,
                                logic [7:0] ewd, logic eir, logic edr);
        vec_t v;
        v = '{r, ir, ia, dr, dw, da, wd, resp, er, ew, ea, ewd, eir, edr};
        return v;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW/32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_pmem_read    = 1'b0;
        bus.i_pmem_address = '0;
        bus.d_pmem_read    = 1'b0;
        bus.d_pmem_write   = 1'b0;
        bus.d_pmem_address = '0;
        bus.d_pmem_wdata   = '0;
        bus.pmem_resp      = 1'b0;
        bus.pmem_rdata     = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // reference-model state: who currently owns memory (0 none, 1 I, 2 D) and the last winner
    int owner;
    bit last_d;

    initial begin
        bit i_on, d_on, i_got, d_got, dsel, exp_d;
        logic          er, ew, eir, edr;
        logic [AW-1:0] ea;
        logic [LW-1:0] ewd;

        tbl[0]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    8'h00, 0, 0, 0, 32'h0,    8'h00, 0, 0);
        tbl[1]  = mk(0, 1, 32'h1000, 0, 0, 32'h0,    8'h00, 0, 0, 0, 32'h0,    8'h00, 0, 0);
        tbl[2]  = mk(0, 1, 32'h1000, 0, 0, 32'h0,    8'h00, 0, 1, 0, 32'h1000, 8'h00, 0, 0);
        tbl[3]  = mk(0, 1, 32'h1000, 0, 0, 32'h0,    8'h00, 0, 1, 0, 32'h1000, 8'h00, 0, 0);
        tbl[4]  = mk(0, 1, 32'h1000, 0, 0, 32'h0,    8'h00, 1, 1, 0, 32'h1000, 8'h00, 1, 0);
        tbl[5]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    8'h00, 0, 0, 0, 32'h0,    8'h00, 0, 0);
        tbl[6]  = mk(0, 0, 32'h0,    0, 1, 32'h2000, 8'hA5, 0, 0, 0, 32'h0,    8'h00, 0, 0);
        tbl[7]  = mk(0, 0, 32'h0,    0, 1, 32'h2000, 8'hA5, 0, 0, 1, 32'h2000, 8'hA5, 0, 0);
        tbl[8]  = mk(0, 0, 32'h0,    0, 1, 32'h2000, 8'hA5, 1, 0, 1, 32'h2000, 8'hA5, 0, 1);
        tbl[9]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    8'h00, 0, 0, 0, 32'h0,    8'h00, 0, 0);
        tbl[10] = mk(0, 0, 32'h0,    0, 0, 32'h0,    8'h00, 1, 0, 0, 32'h0,    8'h00, 0, 0);
        tbl[11] = mk(0, 1, 32'h4000, 0, 0, 32'h0,    8'h00, 1, 0, 0, 32'h0,    8'h00, 0, 0);
        tbl[12] = mk(0, 1, 32'h4000, 0, 0, 32'h0,    8'h00, 0, 1, 0, 32'h4000, 8'h00, 0, 0);
        tbl[13] = mk(0, 1, 32'h4000, 0, 0, 32'h0,    8'h00, 1, 1, 0, 32'h4000, 8'h00, 1, 0);
        tbl[14] = mk(0, 1, 32'h4000, 0, 0, 32'h0,    8'h00, 0, 0, 0, 32'h0,    8'h00, 0, 0);
        tbl[15] = mk(0, 1, 32'h4000, 0, 0, 32'h0,    8'h00, 0, 1, 0, 32'h4000, 8'h00, 0, 0);
        tbl[16] = mk(0, 1, 32'h4000, 0, 0, 32'h0,    8'h00, 1, 1, 0, 32'h4000, 8'h00, 1, 0);
        tbl[17] = mk(0, 0, 32'h0,    0, 0, 32'h0,    8'h00, 0, 0, 0, 32'h0,    8'h00, 0, 0);
        tbl[18] = mk(0, 0, 32'h0,    0, 1, 32'h3000, 8'h5A, 0, 0, 0, 32'h0,    8'h00, 0, 0);
        tbl[19] = mk(0, 0, 32'h0,    0, 1, 32'h3000, 8'h5A, 0, 0, 1, 32'h3000, 8'h5A, 0, 0);
        tbl[20] = mk(1, 0, 32'h0,    0, 1, 32'h3000, 8'h5A, 0, 0, 1, 32'h3000, 8'h5A, 0, 0);
        tbl[21] = mk(0, 0, 32'h0,    0, 1, 32'h3000, 8'h5A, 1, 0, 0, 32'h0,    8'h00, 0, 0);
        tbl[22] = mk(0, 0, 32'h0,    0, 1, 32'h3000, 8'h5A, 0, 0, 1, 32'h3000, 8'h5A, 0, 0);
        tbl[23] = mk(0, 0, 32'h0,    0, 1, 32'h3000, 8'h5A, 1, 0, 1, 32'h3000, 8'h5A, 0, 1);
        tbl[24] = mk(0, 0, 32'h0,    0, 0, 32'h0,    8'h00, 0, 0, 0, 32'h0,    8'h00, 0, 0);

        // directed vector table
        do_reset();
        for (int i = 0; i < NV; i++) begin
            rst                = tbl[i].rst;
            bus.i_pmem_read    = tbl[i].ir;
            bus.i_pmem_address = tbl[i].ia;
            bus.d_pmem_read    = tbl[i].dr;
            bus.d_pmem_write   = tbl[i].dw;
            bus.d_pmem_address = tbl[i].da;
            bus.d_pmem_wdata   = {32{tbl[i].wd}};
            bus.pmem_resp      = tbl[i].resp;
            bus.pmem_rdata     = rand_line();
            @(negedge clk);
            chk($sformatf("vec%0d pmem_read", i),    LW'(bus.pmem_read),    LW'(tbl[i].er));
            chk($sformatf("vec%0d pmem_write", i),   LW'(bus.pmem_write),   LW'(tbl[i].ew));
            chk($sformatf("vec%0d pmem_address", i), LW'(bus.pmem_address), LW'(tbl[i].ea));
            chk($sformatf("vec%0d pmem_wdata", i),   bus.pmem_wdata,        {32{tbl[i].ewd}});
            chk($sformatf("vec%0d i_pmem_resp", i),  LW'(bus.i_pmem_resp),  LW'(tbl[i].eir));
            chk($sformatf("vec%0d d_pmem_resp", i),  LW'(bus.d_pmem_resp),  LW'(tbl[i].edr));
            chk($sformatf("vec%0d i_pmem_rdata", i), bus.i_pmem_rdata,      bus.pmem_rdata);
            chk($sformatf("vec%0d d_pmem_rdata", i), bus.d_pmem_rdata,      bus.pmem_rdata);
            @(posedge clk);
            #1;
        end

        // both caches request together and keep requesting: grant order
        do_reset();
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 32'h1000;
        bus.d_pmem_read    = 1'b1;
        bus.d_pmem_address = 32'h2000;
        for (int t = 0; t < 4; t++) begin
            bus.pmem_resp = 1'b0;
            @(negedge clk);
            chk($sformatf("both%0d bubble pmem_read", t), LW'(bus.pmem_read), LW'(1'b0));
            @(posedge clk);
            #1 bus.pmem_resp = 1'b1;
            exp_d = RR ? (t % 2 == 0) : 1'b1;
            @(negedge clk);
            chk($sformatf("both%0d grant addr", t), LW'(bus.pmem_address), exp_d ? LW'(32'h2000) : LW'(32'h1000));
            chk($sformatf("both%0d d_resp", t), LW'(bus.d_pmem_resp), LW'(exp_d));
            chk($sformatf("both%0d i_resp", t), LW'(bus.i_pmem_resp), LW'(!exp_d));
            @(posedge clk);
            #1;
        end
        idle_inputs();

        // random traffic against the reference model
        owner = 0; last_d = 1'b0;
        i_on = 1'b0; d_on = 1'b0; i_got = 1'b0; d_got = 1'b0; dsel = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = (c == 0) || ($urandom_range(0, 149) == 0);
            if (!i_on || i_got) begin
                i_on = ($urandom_range(0, 2) != 0);
                bus.i_pmem_address = $urandom;
            end
            if (!d_on || d_got) begin
                d_on = ($urandom_range(0, 2) != 0);
                dsel = $urandom_range(0, 1);
                bus.d_pmem_address = $urandom;
                bus.d_pmem_wdata   = rand_line();
            end
            bus.i_pmem_read  = i_on;
            bus.d_pmem_read  = d_on && !dsel;
            bus.d_pmem_write = d_on && dsel;
            bus.pmem_resp    = ($urandom_range(0, 2) == 0);
            bus.pmem_rdata   = rand_line();

            er = 1'b0; ew = 1'b0; ea = '0; ewd = '0; eir = 1'b0; edr = 1'b0;
            if (owner == 1) begin
                er = bus.i_pmem_read; ea = bus.i_pmem_address; eir = bus.pmem_resp;
            end else if (owner == 2) begin
                er = bus.d_pmem_read; ew = bus.d_pmem_write; ea = bus.d_pmem_address;
                ewd = bus.d_pmem_wdata; edr = bus.pmem_resp;
            end

            @(negedge clk);
            chk("rnd pmem_read",    LW'(bus.pmem_read),    LW'(er));
            chk("rnd pmem_write",   LW'(bus.pmem_write),   LW'(ew));
            chk("rnd pmem_address", LW'(bus.pmem_address), LW'(ea));
            chk("rnd pmem_wdata",   bus.pmem_wdata,        ewd);
            chk("rnd i_pmem_resp",  LW'(bus.i_pmem_resp),  LW'(eir));
            chk("rnd d_pmem_resp",  LW'(bus.d_pmem_resp),  LW'(edr));
            chk("rnd i_pmem_rdata", bus.i_pmem_rdata,      bus.pmem_rdata);
            chk("rnd d_pmem_rdata", bus.d_pmem_rdata,      bus.pmem_rdata);
            i_got = eir;
            d_got = edr;

            if (rst) begin
                owner  = 0;
                last_d = 1'b0;
            end else if (owner == 0) begin
                if (i_on && d_on)  owner = (RR && last_d) ? 1 : 2;
                else if (i_on)     owner = 1;
                else if (d_on)     owner = 2;
                if (owner == 1) last_d = 1'b0;
                if (owner == 2) last_d = 1'b1;
            end else if (bus.pmem_resp) begin
                owner = 0;
            end
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
